// File: rtl/mslot_pkg.sv
// Shared constants and records for the multi-slot hazard/forwarding unit.
// Select encoding: RF, then M-stage slots, then W-stage slots.
package mslot_pkg;

   localparam int unsigned MSLOT_NUM_SLOTS = 2;
   localparam int unsigned MSLOT_REG_AW    = 5;

   localparam int unsigned FWD_RF     = 0;
   localparam int unsigned FWD_M_BASE = 1;
   localparam int unsigned FWD_W_BASE = FWD_M_BASE + MSLOT_NUM_SLOTS;

   // Per-stage control record shadowed alongside the register tags.
   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memtoreg;
   } stage_ctl_t;

endpackage

// File: rtl/mslot_fwd_select.sv
// Priority match of one source tag against the M and W producer tags.
// M beats W; within a stage the higher (younger) slot wins.
module mslot_fwd_select
   import mslot_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = MSLOT_NUM_SLOTS,
   parameter int unsigned REG_AW    = MSLOT_REG_AW,
   parameter int unsigned SELW      = $clog2(2*NUM_SLOTS+1)
) (
   input  logic [REG_AW-1:0]           src,
   input  logic [NUM_SLOTS-1:0]        m_we,
   input  logic [NUM_SLOTS*REG_AW-1:0] m_dst,
   input  logic [NUM_SLOTS-1:0]        w_we,
   input  logic [NUM_SLOTS*REG_AW-1:0] w_dst,
   output logic [SELW-1:0]             sel_c
);

   // W base rebased to this instance's slot count.
   localparam int unsigned W_BASE = FWD_W_BASE - MSLOT_NUM_SLOTS + NUM_SLOTS;

   // Later assignments win: W ascending, then M ascending overrides W.
   always_comb begin
      sel_c = SELW'(FWD_RF);
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if (w_we[k] && (src != '0) && (w_dst[k*REG_AW +: REG_AW] == src))
            sel_c = SELW'(W_BASE + k);
      end
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if (m_we[k] && (src != '0) && (m_dst[k*REG_AW +: REG_AW] == src))
            sel_c = SELW'(FWD_M_BASE + k);
      end
   end

endmodule

// File: rtl/mslot_hazard_fwd_unit.sv
// N-slot hazard/forwarding unit: E/M/W tag shadows, E-stage selects, load-use and split issue.
// Optional MSLOT_BRANCH_FWD_EN adds D-stage branch selects and branch stalls.
module mslot_hazard_fwd_unit
   import mslot_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = MSLOT_NUM_SLOTS,
   parameter int unsigned REG_AW    = MSLOT_REG_AW,
   parameter int unsigned SELW      = $clog2(2*NUM_SLOTS+1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SLOTS-1:0]        d_valid,
   input  logic [NUM_SLOTS*REG_AW-1:0] d_rs,
   input  logic [NUM_SLOTS*REG_AW-1:0] d_rt,
   input  logic [NUM_SLOTS*REG_AW-1:0] d_dst,
   input  logic [NUM_SLOTS-1:0]        d_regwrite,
   input  logic [NUM_SLOTS-1:0]        d_memtoreg,
   input  logic                        flush_e,
   input  logic                        stall_ext,
`ifdef MSLOT_BRANCH_FWD_EN
   input  logic [NUM_SLOTS-1:0]        d_branch,
   output logic [NUM_SLOTS*SELW-1:0]   fwd_a_d,
   output logic [NUM_SLOTS*SELW-1:0]   fwd_b_d,
`endif
   output logic [NUM_SLOTS*SELW-1:0]   fwd_a_e,
   output logic [NUM_SLOTS*SELW-1:0]   fwd_b_e,
   output logic                        stall_d,
   output logic [NUM_SLOTS-1:0]        issue_mask
);

   localparam int unsigned TW = NUM_SLOTS * REG_AW;

   stage_ctl_t [NUM_SLOTS-1:0] e_ctl;
   logic [TW-1:0]              e_dst, e_rs, e_rt;
   logic [NUM_SLOTS-1:0]       m_we, w_we;
   logic [TW-1:0]              m_dst, w_dst;
   logic [NUM_SLOTS-1:0]       done_q;
`ifdef MSLOT_BRANCH_FWD_EN
   logic [NUM_SLOTS-1:0]       m_ld;
`endif

   logic [REG_AW-1:0]    rs_d [NUM_SLOTS];
   logic [REG_AW-1:0]    rt_d [NUM_SLOTS];
   logic [REG_AW-1:0]    dst_d [NUM_SLOTS];
   logic [REG_AW-1:0]    dst_e [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] pending, dep, issue, done_nxt;
   logic                 hazard, split, blocked, flush_eff;

   function automatic logic reads_tag(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b,
                                      input logic [REG_AW-1:0] t);
      return (t != '0) && ((a == t) || (b == t));
   endfunction

   always_comb begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         rs_d[k]  = d_rs[k*REG_AW +: REG_AW];
         rt_d[k]  = d_rt[k*REG_AW +: REG_AW];
         dst_d[k] = d_dst[k*REG_AW +: REG_AW];
         dst_e[k] = e_dst[k*REG_AW +: REG_AW];
      end
   end

   // Hazard detection over the slots still waiting to issue.
   always_comb begin
      pending = d_valid & ~done_q;
      hazard  = 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
            if (pending[k] && e_ctl[j].valid && e_ctl[j].regwrite && e_ctl[j].memtoreg &&
                reads_tag(rs_d[k], rt_d[k], dst_e[j]))
               hazard = 1'b1;
`ifdef MSLOT_BRANCH_FWD_EN
            if (pending[k] && d_branch[k] && e_ctl[j].valid && e_ctl[j].regwrite &&
                reads_tag(rs_d[k], rt_d[k], dst_e[j]))
               hazard = 1'b1;
            if (pending[k] && d_branch[k] && m_ld[j] &&
                reads_tag(rs_d[k], rt_d[k], m_dst[j*REG_AW +: REG_AW]))
               hazard = 1'b1;
`endif
         end
      end

      dep = '0;
      for (int unsigned j = 1; j < NUM_SLOTS; j++) begin
         for (int unsigned i = 0; i < j; i++) begin
            if (pending[i] && pending[j] && d_regwrite[i] &&
                reads_tag(rs_d[j], rt_d[j], dst_d[i]))
               dep[j] = 1'b1;
         end
      end
      split = |dep;

      // Issue stops at the first dependent slot.
      blocked = 1'b0;
      issue   = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         blocked  = blocked | dep[k];
         issue[k] = pending[k] & ~blocked;
      end
   end

   // Issue control; reset and flush override any hazard.
   always_comb begin
      flush_eff  = flush_e & ~stall_ext;
      stall_d    = 1'b0;
      issue_mask = pending;
      done_nxt   = '0;
      if (reset) begin
         issue_mask = d_valid;
      end else if (flush_eff) begin
         issue_mask = '0;
      end else if (hazard) begin
         stall_d    = 1'b1;
         issue_mask = '0;
         done_nxt   = done_q;
      end else if (split) begin
         stall_d    = 1'b1;
         issue_mask = issue;
         done_nxt   = done_q | issue;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_ctl  <= '0;
         e_dst  <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         m_we   <= '0;
         m_dst  <= '0;
         w_we   <= '0;
         w_dst  <= '0;
         done_q <= '0;
`ifdef MSLOT_BRANCH_FWD_EN
         m_ld   <= '0;
`endif
      end else if (!stall_ext) begin
         for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            e_ctl[k].valid    <= issue_mask[k];
            e_ctl[k].regwrite <= d_regwrite[k];
            e_ctl[k].memtoreg <= d_memtoreg[k];
            m_we[k]           <= e_ctl[k].valid & e_ctl[k].regwrite;
`ifdef MSLOT_BRANCH_FWD_EN
            m_ld[k]           <= e_ctl[k].valid & e_ctl[k].regwrite & e_ctl[k].memtoreg;
`endif
         end
         e_dst  <= d_dst;
         e_rs   <= d_rs;
         e_rt   <= d_rt;
         m_dst  <= e_dst;
         w_we   <= m_we;
         w_dst  <= m_dst;
         done_q <= done_nxt;
      end
   end

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_fwd
      mslot_fwd_select #(.NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .SELW(SELW)) u_fwd_a (
         .src   (e_rs[k*REG_AW +: REG_AW]),
         .m_we  (m_we),
         .m_dst (m_dst),
         .w_we  (w_we),
         .w_dst (w_dst),
         .sel_c (fwd_a_e[k*SELW +: SELW])
      );
      mslot_fwd_select #(.NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .SELW(SELW)) u_fwd_b (
         .src   (e_rt[k*REG_AW +: REG_AW]),
         .m_we  (m_we),
         .m_dst (m_dst),
         .w_we  (w_we),
         .w_dst (w_dst),
         .sel_c (fwd_b_e[k*SELW +: SELW])
      );
`ifdef MSLOT_BRANCH_FWD_EN
      mslot_fwd_select #(.NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .SELW(SELW)) u_fwd_a_d (
         .src   (d_rs[k*REG_AW +: REG_AW]),
         .m_we  (m_we),
         .m_dst (m_dst),
         .w_we  (w_we),
         .w_dst (w_dst),
         .sel_c (fwd_a_d[k*SELW +: SELW])
      );
      mslot_fwd_select #(.NUM_SLOTS(NUM_SLOTS), .REG_AW(REG_AW), .SELW(SELW)) u_fwd_b_d (
         .src   (d_rt[k*REG_AW +: REG_AW]),
         .m_we  (m_we),
         .m_dst (m_dst),
         .w_we  (w_we),
         .w_dst (w_dst),
         .sel_c (fwd_b_d[k*SELW +: SELW])
      );
`endif
   end

endmodule

// File: tb/tb_mslot_hazard_fwd_unit.sv
// Bench for mslot_hazard_fwd_unit: instruction-level pipeline model, directed cases, random traffic.
module tb_mslot_hazard_fwd_unit;

   localparam int unsigned N    = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned SELW = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      d_valid, d_regwrite, d_memtoreg;
   logic [N*AW-1:0]   d_rs, d_rt, d_dst;
   logic              flush_e, stall_ext;
   logic [N*SELW-1:0] fwd_a_e, fwd_b_e;
   logic              stall_d;
   logic [N-1:0]      issue_mask;
`ifdef MSLOT_BRANCH_FWD_EN
   logic [N-1:0]      d_branch = '0;
   logic [N*SELW-1:0] fwd_a_d, fwd_b_d;
`endif

   mslot_hazard_fwd_unit #(.NUM_SLOTS(N), .REG_AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_dst      (d_dst),
      .d_regwrite (d_regwrite),
      .d_memtoreg (d_memtoreg),
      .flush_e    (flush_e),
      .stall_ext  (stall_ext),
`ifdef MSLOT_BRANCH_FWD_EN
      .d_branch   (d_branch),
      .fwd_a_d    (fwd_a_d),
      .fwd_b_d    (fwd_b_d),
`endif
      .fwd_a_e    (fwd_a_e),
      .fwd_b_e    (fwd_b_e),
      .stall_d    (stall_d),
      .issue_mask (issue_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      bit rw;
      bit ld;
      int dst;
      int rs;
      int rt;
   } ins_t;

   ins_t   dd [N];
   ins_t   me [N];
   ins_t   mm [N];
   ins_t   mw [N];
   bit [N-1:0] mdone;
   bit         exp_stall;
   bit [N-1:0] exp_mask, exp_done_nxt;
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         me[k] = '{0, 0, 0, 0, 0, 0};
         mm[k] = '{0, 0, 0, 0, 0, 0};
         mw[k] = '{0, 0, 0, 0, 0, 0};
      end
      mdone = '0;
   endtask

   task automatic clr_bundle();
      for (int k = 0; k < N; k++) dd[k] = '{0, 0, 0, 0, 0, 0};
   endtask

   task automatic set_slot(input int k, input int rs, input int rt, input int dst,
                           input bit rw, input bit ld);
      dd[k] = '{1, rw, ld, dst, rs, rt};
   endtask

   task automatic apply();
      for (int k = 0; k < N; k++) begin
         d_valid[k]            = dd[k].v;
         d_regwrite[k]         = dd[k].rw;
         d_memtoreg[k]         = dd[k].ld;
         d_rs[k*AW +: AW]      = AW'(dd[k].rs);
         d_rt[k*AW +: AW]      = AW'(dd[k].rt);
         d_dst[k*AW +: AW]     = AW'(dd[k].dst);
      end
   endtask

   // Youngest M producer, else youngest W producer, else register file.
   function automatic int exp_sel(input int src);
      if (src == 0) return 0;
      for (int k = N-1; k >= 0; k--)
         if (mm[k].v && mm[k].rw && mm[k].dst == src) return 1 + k;
      for (int k = N-1; k >= 0; k--)
         if (mw[k].v && mw[k].rw && mw[k].dst == src) return 1 + N + k;
      return 0;
   endfunction

   function automatic bit reads(input ins_t c, input int t);
      return (t != 0) && (c.rs == t || c.rt == t);
   endfunction

   function automatic int first_dep(input bit [N-1:0] p);
      for (int j = 0; j < N; j++)
         for (int i = 0; i < j; i++)
            if (p[i] && p[j] && dd[i].rw && reads(dd[j], dd[i].dst)) return j;
      return N;
   endfunction

   // Compare all meaningful outputs against the model, half a cycle after the edge.
   task automatic check_now();
      bit [N-1:0] p;
      bit         lu;
      int         fd;
      @(negedge clk);
      lu = 1'b0;
      for (int k = 0; k < N; k++) p[k] = dd[k].v && !mdone[k];
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++)
            if (p[k] && me[j].v && me[j].rw && me[j].ld && reads(dd[k], me[j].dst)) lu = 1'b1;
      exp_done_nxt = '0;
      if (reset) begin
         exp_stall = 1'b0;
         for (int k = 0; k < N; k++) exp_mask[k] = dd[k].v;
      end else if (flush_e && !stall_ext) begin
         exp_stall = 1'b0;
         exp_mask  = '0;
      end else if (lu) begin
         exp_stall    = 1'b1;
         exp_mask     = '0;
         exp_done_nxt = mdone;
      end else begin
         fd = first_dep(p);
         exp_mask = '0;
         for (int k = 0; k < N; k++) exp_mask[k] = p[k] && (k < fd);
         exp_stall = (fd < N);
         if (exp_stall) exp_done_nxt = mdone | exp_mask;
      end
      chk("stall_d", int'(stall_d), int'(exp_stall));
      chk("issue_mask", int'(issue_mask), int'(exp_mask));
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            if (me[k].v) begin
               chk($sformatf("fwd_a_e[%0d]", k), int'(fwd_a_e[k*SELW +: SELW]), exp_sel(me[k].rs));
               chk($sformatf("fwd_b_e[%0d]", k), int'(fwd_b_e[k*SELW +: SELW]), exp_sel(me[k].rt));
            end
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      if (!reset && !stall_ext) begin
         mw = mm;
         mm = me;
         for (int k = 0; k < N; k++) begin
            me[k]   = dd[k];
            me[k].v = exp_mask[k] && !flush_e;
         end
         mdone = exp_done_nxt;
      end
      #1;
   endtask

   task automatic cyc();
      apply();
      check_now();
   endtask

   task automatic drain();
      clr_bundle();
      flush_e   = 1'b0;
      stall_ext = 1'b0;
      repeat (3) begin cyc(); adv(); end
   endtask

   initial begin
      bit new_b;
      reset     = 1'b1;
      flush_e   = 1'b0;
      stall_ext = 1'b0;
      model_clear();
      clr_bundle();
      dd[1].v = 1'b1;
      cyc();
      chk("rst_stall_d", int'(stall_d), 0);
      chk("rst_issue_mask", int'(issue_mask), 2);
      chk("rst_fwd_a_e", int'(fwd_a_e), 0);
      chk("rst_fwd_b_e", int'(fwd_b_e), 0);
      adv();
      reset = 1'b0;

      // Producer in M slot1 feeds E slot0.
      drain();
      set_slot(1, 1, 2, 3, 1, 0);            cyc(); adv();
      clr_bundle(); set_slot(0, 3, 0, 9, 1, 0); cyc(); adv();
      clr_bundle();                          cyc();
      chk("m_slot1_fwd", int'(fwd_a_e[0 +: SELW]), 2);
      adv();

      // Same tag in M slot0 and W slot1: M wins.
      drain();
      set_slot(1, 1, 2, 3, 1, 0);               cyc(); adv();
      clr_bundle(); set_slot(0, 1, 2, 3, 1, 0); cyc(); adv();
      clr_bundle(); set_slot(0, 3, 0, 10, 1, 0); cyc(); adv();
      clr_bundle();                             cyc();
      chk("m_beats_w", int'(fwd_a_e[0 +: SELW]), 1);
      adv();

      // Load-use: one bubble, then the load has reached W when the consumer is in E.
      drain();
      set_slot(0, 1, 2, 5, 1, 1); cyc(); adv();
      clr_bundle();
      set_slot(0, 1, 2, 9, 1, 0);
      set_slot(1, 5, 0, 10, 1, 0);
      cyc();
      chk("lu_stall", int'(stall_d), 1);
      chk("lu_mask", int'(issue_mask), 0);
      adv();
      cyc();
      chk("lu_rel_stall", int'(stall_d), 0);
      chk("lu_rel_mask", int'(issue_mask), 3);
      adv();
      clr_bundle(); cyc();
      chk("lu_fwd_w0", int'(fwd_a_e[SELW +: SELW]), 3);
      adv();

      // Intra-bundle RAW split.
      drain();
      set_slot(0, 1, 2, 7, 1, 0);
      set_slot(1, 7, 0, 11, 1, 0);
      cyc();
      chk("split1_mask", int'(issue_mask), 1);
      chk("split1_stall", int'(stall_d), 1);
      adv();
      cyc();
      chk("split2_mask", int'(issue_mask), 2);
      chk("split2_stall", int'(stall_d), 0);
      adv();
      clr_bundle(); cyc();
      chk("split3_fwd", int'(fwd_a_e[SELW +: SELW]), 1);
      adv();

      // Writes to $0 never forward.
      drain();
      set_slot(0, 1, 2, 0, 1, 0); set_slot(1, 1, 2, 0, 1, 0); cyc(); adv();
      cyc(); adv();
      clr_bundle(); set_slot(0, 0, 0, 12, 1, 0); set_slot(1, 0, 0, 13, 1, 0); cyc(); adv();
      clr_bundle(); cyc();
      chk("r0_fwd_a", int'(fwd_a_e), 0);
      chk("r0_fwd_b", int'(fwd_b_e), 0);
      adv();

      // Flush coincident with load-use.
      drain();
      set_slot(0, 1, 2, 5, 1, 1); cyc(); adv();
      clr_bundle(); set_slot(1, 5, 0, 10, 1, 0);
      flush_e = 1'b1;
      cyc();
      chk("flush_stall", int'(stall_d), 0);
      chk("flush_mask", int'(issue_mask), 0);
      adv();
      flush_e = 1'b0;
      cyc();
      chk("flush_e_clr_stall", int'(stall_d), 0);
      chk("flush_e_clr_mask", int'(issue_mask), 2);
      adv();

      // External freeze mid-split holds everything.
      drain();
      set_slot(0, 1, 2, 4, 1, 0); cyc(); adv();
      clr_bundle();
      set_slot(0, 4, 2, 6, 1, 0);
      set_slot(1, 4, 6, 14, 1, 0);
      cyc();
      chk("frz_split_mask", int'(issue_mask), 1);
      adv();
      stall_ext = 1'b1;
      repeat (3) begin
         cyc();
         chk("frz_fwd", int'(fwd_a_e[0 +: SELW]), 1);
         chk("frz_mask", int'(issue_mask), 2);
         chk("frz_stall", int'(stall_d), 0);
         adv();
      end
      stall_ext = 1'b0;
      cyc(); adv();

      // Asynchronous reset in the middle of a split.
      drain();
      set_slot(0, 1, 2, 8, 1, 0);
      set_slot(1, 8, 0, 15, 1, 0);
      cyc();
      chk("rsplit_mask", int'(issue_mask), 1);
      adv();
      #2 reset = 1'b1;
      model_clear();
      #1;
      chk("rsplit_rst_stall", int'(stall_d), 0);
      chk("rsplit_rst_mask", int'(issue_mask), 3);
      check_now();
      adv();
      reset = 1'b0;
      clr_bundle();
      set_slot(0, 1, 2, 9, 1, 0);
      set_slot(1, 3, 4, 10, 1, 0);
      cyc();
      chk("rsplit_full_mask", int'(issue_mask), 3);
      chk("rsplit_full_stall", int'(stall_d), 0);
      adv();

      // Random traffic; D is held whenever the front end is stalled.
      new_b = 1'b1;
      repeat (1500) begin
         if (new_b) begin
            for (int k = 0; k < N; k++) begin
               dd[k].v   = 1'($urandom_range(0, 1));
               dd[k].rw  = ($urandom_range(0, 3) != 0);
               dd[k].ld  = dd[k].rw && ($urandom_range(0, 2) == 0);
               dd[k].dst = int'($urandom_range(0, 7));
               dd[k].rs  = int'($urandom_range(0, 7));
               dd[k].rt  = int'($urandom_range(0, 7));
            end
         end
         stall_ext = ($urandom_range(0, 7) == 0);
         flush_e   = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         if (reset) model_clear();
         cyc();
         new_b = !exp_stall && !stall_ext;
         adv();
      end
      reset     = 1'b0;
      stall_ext = 1'b0;
      flush_e   = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
